// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx
//   Serialises 16-bit stereo sample pairs to the codec DAC in Philips I2S
//   format. bclk and lrclk are derived from clk_144 by an integer divider.
//   A one-deep holding register decouples the DSP side. If no pair is waiting
//   at a frame boundary, a silent frame is sent and underrun is flagged.
//
// Parameters
//   WIDTH      sample width in bits
//   SLOT_BITS  bclk periods per channel slot (>= WIDTH), sample left-justified
//   BCLK_DIV   clk_144 cycles per bclk half-period (>= 1)
//
// Ports
//   clk_144      system clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       serialiser running when high; serial outputs idle when low
//   in_left      signed left sample
//   in_right     signed right sample
//   in_valid     sample pair present
//   in_ready     holding register empty (registered)
//   bclk         I2S bit clock
//   lrclk        word select, 0 = left, 1 = right
//   sdata        serial data, MSB first
//   frame_start  one-cycle pulse at each frame load
//   underrun     one-cycle pulse when a frame load found holding empty
module i2s_dac_tx #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SLOT_BITS = 16,
  parameter int unsigned BCLK_DIV  = 2
) (
  input  logic             clk_144,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             frame_start,
  output logic             underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned PAD        = SLOT_BITS - WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [WIDTH-1:0]      hold_l;
  logic [WIDTH-1:0]      hold_r;
  logic                  hold_full;

  logic                  accept;
  logic                  fall_evt;
  logic                  load_evt;
  logic                  hold_full_nxt;
  logic [SLOT_BITS-1:0]  slot_l;
  logic [SLOT_BITS-1:0]  slot_r;

  // Samples are left-justified in their slot, low bits zero-padded.
  assign slot_l = SLOT_BITS'(hold_l) << PAD;
  assign slot_r = SLOT_BITS'(hold_r) << PAD;

  always_comb begin
    accept        = in_valid & in_ready;
    fall_evt      = enable & bclk & (div_cnt == DIV_LAST);
    load_evt      = fall_evt & (bit_cnt == '0);
    hold_full_nxt = hold_full;
    if (load_evt) begin
      hold_full_nxt = 1'b0;
    end
    // in_ready mirrors !hold_full, so an accept never coincides with a load
    // that drains a full holding register.
    if (accept) begin
      hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      hold_full   <= 1'b0;
      in_ready    <= 1'b1;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold_full   <= hold_full_nxt;
      in_ready    <= ~hold_full_nxt;
      if (accept) begin
        hold_l <= in_left;
        hold_r <= in_right;
      end

      if (!enable) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        shreg   <= '0;
        bclk    <= 1'b0;
        lrclk   <= 1'b0;
        sdata   <= 1'b0;
      end else begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + DIV_ONE;
        end

        if (fall_evt) begin
          lrclk   <= (bit_cnt >= SLOT_LEN);
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
          // The shifter is loaded at i=0 but shifted out starting at i=1,
          // which yields the one-bclk I2S delay: at i=0 its MSB is still the
          // last bit of the previous frame.
          sdata   <= shreg[FRAME_BITS-1];
          if (bit_cnt == '0) begin
            shreg       <= hold_full ? {slot_l, slot_r} : '0;
            frame_start <= 1'b1;
            underrun    <= ~hold_full;
          end else begin
            shreg <= shreg << 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx
//   Directed bench for i2s_dac_tx: default instance (16/16/2) and a padded
//   instance (16/24/1). Serial bits are captured on every bclk rise; frame
//   boundaries are marked by frame_start, so frame n bit k (from MSB) sits at
//   stream index fs_pos[n] + k + 1.
module tb_i2s_dac_tx;

  logic        clk_144 = 1'b0;
  logic        reset_n;
  logic        enable, in_valid;
  logic [15:0] in_left, in_right;
  logic        in_ready, bclk, lrclk, sdata, frame_start, underrun;

  logic        enable_p, in_valid_p;
  logic [15:0] in_left_p, in_right_p;
  logic        in_ready_p, bclk_p, lrclk_p, sdata_p, frame_start_p, underrun_p;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk_144 = ~clk_144;
  always @(posedge clk_144) cyc++;

  i2s_dac_tx dut (
    .clk_144(clk_144), .reset_n(reset_n), .enable(enable),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  i2s_dac_tx #(.WIDTH(16), .SLOT_BITS(24), .BCLK_DIV(1)) dut_pad (
    .clk_144(clk_144), .reset_n(reset_n), .enable(enable_p),
    .in_left(in_left_p), .in_right(in_right_p), .in_valid(in_valid_p),
    .in_ready(in_ready_p), .bclk(bclk_p), .lrclk(lrclk_p), .sdata(sdata_p),
    .frame_start(frame_start_p), .underrun(underrun_p)
  );

  // Capture state, default instance
  logic st[$];
  logic lr[$];
  int   fs_pos[$];
  int   fs_cyc[$];
  logic fs_ur[$];
  int   rise_cyc[$];
  int   stray_ur = 0;
  logic bclk_prev = 1'b0;

  // Capture state, padded instance
  logic st_p[$];
  logic lr_p[$];
  int   fs_pos_p[$];
  int   fs_cyc_p[$];
  int   rise_cyc_p[$];
  logic bclk_prev_p = 1'b0;

  always @(negedge clk_144) begin
    if (frame_start) begin
      fs_pos.push_back(st.size());
      fs_cyc.push_back(cyc);
      fs_ur.push_back(underrun);
    end else if (underrun) begin
      stray_ur++;
    end
    if (bclk && !bclk_prev) begin
      st.push_back(sdata);
      lr.push_back(lrclk);
      rise_cyc.push_back(cyc);
    end
    bclk_prev = bclk;

    if (frame_start_p) begin
      fs_pos_p.push_back(st_p.size());
      fs_cyc_p.push_back(cyc);
    end
    if (bclk_p && !bclk_prev_p) begin
      st_p.push_back(sdata_p);
      lr_p.push_back(lrclk_p);
      rise_cyc_p.push_back(cyc);
    end
    bclk_prev_p = bclk_p;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_144);
    #1;
  endtask

  task automatic clear_q();
    st.delete(); lr.delete(); fs_pos.delete(); fs_cyc.delete();
    fs_ur.delete(); rise_cyc.delete();
  endtask

  // Reads n stream bits MSB-first; all-ones if the stream is too short.
  function automatic logic [31:0] word_a(input int base, input int n, input bit pad);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      if (!pad && base + k < st.size())        w = {w[30:0], st[base+k]};
      else if (pad && base + k < st_p.size())  w = {w[30:0], st_p[base+k]};
      else return 32'hFFFF_FFFF;
    end
    return w;
  endfunction

  function automatic int lr_ones(input int base, input int n, input bit pad);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) begin
      if (!pad && base + k < lr.size())       c += int'(lr[base+k]);
      else if (pad && base + k < lr_p.size()) c += int'(lr_p[base+k]);
      else c += 100;
    end
    return c;
  endfunction

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    while (!in_ready && n < 1000) begin
      tick(1);
      n++;
    end
    check("send_ready", 32'(in_ready), 1);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_fs(input int n, input int limit);
    int c;
    c = 0;
    while (fs_pos.size() < n && c < limit) begin
      tick(1);
      c++;
    end
    if (fs_pos.size() < n) check("frame_timeout", 32'(fs_pos.size()), 32'(n));
  endtask

  int          bad, k_acc, en_cyc, base, lim;
  logic        acc, prev_rdy;
  logic [15:0] exp_l, exp_r;
  int          acc_cyc[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    enable_p = 1'b0; in_valid_p = 1'b0; in_left_p = '0; in_right_p = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Reset mid-operation with a pending holding pair, then idle.
    send(16'h1111, 16'h2222);
    enable = 1'b1;
    tick(10);
    send(16'h3333, 16'h4444);
    tick(30);
    check("pre_reset_ready", 32'(in_ready), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outs", 32'({bclk, lrclk, sdata, frame_start, underrun}), 0);
    check("async_reset_ready", 32'(in_ready), 1);
    enable = 1'b0;
    @(posedge clk_144);
    #1;
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      if ({bclk, lrclk, sdata, frame_start, underrun} != 5'b0 || !in_ready) bad++;
    end
    check("idle_50", 32'(bad), 0);

    // Single frame, defaults.
    send(16'h8001, 16'h7FFE);
    check("accept_while_disabled", 32'(in_ready), 0);
    clear_q();
    enable = 1'b1;
    en_cyc = cyc;
    wait_fs(2, 400);
    tick(8);
    base = fs_pos[0];
    check("first_load_latency", 32'(fs_cyc[0] - en_cyc), 4);
    check("single_no_underrun", 32'(fs_ur[0]), 0);
    check("single_left", word_a(base + 1, 16, 0), 32'h8001);
    check("left_lsb_at_r0", 32'({st[base+16], lr[base+16]}), 32'b11);
    check("single_right", word_a(base + 17, 16, 0), 32'h7FFE);
    check("bclk_period", 32'(rise_cyc[1] - rise_cyc[0]), 4);
    check("frame_cycles", 32'(fs_cyc[1] - fs_cyc[0]), 128);
    check("lrclk_high_count", 32'(lr_ones(base, 32, 0)), 16);
    check("lrclk_edge", 32'({lr[base+15], lr[base+16]}), 32'b01);
    check("second_underrun", 32'(fs_ur[1]), 1);

    // Underrun, then a pair delivered mid-frame.
    enable = 1'b0;
    tick(4);
    clear_q();
    enable = 1'b1;
    wait_fs(1, 300);
    check("ur_flag", 32'(fs_ur[0]), 1);
    tick(60);
    send(16'h1357, 16'hA5C3);
    wait_fs(3, 400);
    tick(8);
    base = fs_pos[0];
    check("ur_silent_left", word_a(base + 1, 16, 0), 0);
    check("ur_silent_right", word_a(base + 17, 16, 0), 0);
    check("ur_next_flag", 32'(fs_ur[1]), 0);
    check("ur_next_left", word_a(fs_pos[1] + 1, 16, 0), 32'h1357);
    check("ur_next_right", word_a(fs_pos[1] + 17, 16, 0), 32'hA5C3);

    // Streaming with a source that always has data.
    enable = 1'b0;
    tick(4);
    clear_q();
    k_acc = 0;
    in_left  = 16'hFFFE;
    in_right = 16'h7FFE;
    in_valid = 1'b1;
    prev_rdy = in_ready;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk_144);
      acc = in_valid && in_ready;
      if (frame_start && k_acc > 0 && k_acc < 6) begin
        check("strm_ready_before_fs", 32'(prev_rdy), 0);
        check("strm_ready_at_fs", 32'(in_ready), 1);
      end
      prev_rdy = in_ready;
      @(posedge clk_144);
      #1;
      if (acc) begin
        acc_cyc.push_back(cyc);
        check("strm_ready_fall", 32'(in_ready), 0);
        k_acc++;
        if (k_acc < 6) begin
          in_left  = 16'(16'hFFFE + k_acc);
          in_right = 16'(16'h7FFE + k_acc);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (c == 3) enable = 1'b1;
      if (fs_pos.size() >= 7 && st.size() > fs_pos[6]) break;
    end
    check("strm_accepts", 32'(k_acc), 6);
    check("strm_frames", 32'(fs_pos.size() >= 7), 1);
    lim = (acc_cyc.size() < 6) ? acc_cyc.size() : 6;
    for (int k = 1; k + 1 < lim; k++)
      check("strm_accept_interval", 32'(acc_cyc[k+1] - acc_cyc[k]), 128);
    lim = (fs_pos.size() < 6) ? fs_pos.size() : 6;
    for (int k = 0; k < lim; k++) begin
      exp_l = 16'(16'hFFFE + k);
      exp_r = 16'(16'h7FFE + k);
      check("strm_no_underrun", 32'(fs_ur[k]), 0);
      check("strm_left", word_a(fs_pos[k] + 1, 16, 0), 32'(exp_l));
      check("strm_right", word_a(fs_pos[k] + 17, 16, 0), 32'(exp_r));
    end

    // Enable dropped at bit_cnt=20, then restarted.
    enable = 1'b0;
    tick(4);
    clear_q();
    send(16'h0F0F, 16'hFFFF);
    enable = 1'b1;
    wait_fs(1, 300);
    send(16'h5A5A, 16'h3C3C);
    base = (fs_pos.size() > 0) ? fs_pos[0] : 0;
    for (int c = 0; c < 200 && st.size() < base + 20; c++) @(negedge clk_144);
    check("pre_drop_lr_sd", 32'({lrclk, sdata}), 32'b11);
    enable = 1'b0;
    @(posedge clk_144);
    #1;
    check("drop_outputs", 32'({bclk, lrclk, sdata}), 0);
    check("drop_keeps_holding", 32'(in_ready), 0);
    tick(20);
    clear_q();
    enable = 1'b1;
    en_cyc = cyc;
    wait_fs(2, 400);
    tick(8);
    check("reen_latency", 32'(fs_cyc[0] - en_cyc), 4);
    check("reen_no_underrun", 32'(fs_ur[0]), 0);
    check("reen_left", word_a(fs_pos[0] + 1, 16, 0), 32'h5A5A);
    check("reen_right", word_a(fs_pos[0] + 17, 16, 0), 32'h3C3C);
    check("reen_next_underrun", 32'(fs_ur[1]), 1);
    enable = 1'b0;

    // Padding instance: 24-bit slots, bclk = clk_144 / 2.
    in_left_p  = 16'h1234;
    in_right_p = 16'hABCD;
    in_valid_p = 1'b1;
    tick(1);
    in_valid_p = 1'b0;
    enable_p = 1'b1;
    for (int c = 0; c < 400 && fs_pos_p.size() < 2; c++) tick(1);
    check("pad_frames", 32'(fs_pos_p.size() >= 2), 1);
    tick(4);
    if (fs_pos_p.size() >= 2) begin
      base = fs_pos_p[0];
      check("pad_left", word_a(base + 1, 24, 1), 32'h123400);
      check("pad_right", word_a(base + 25, 24, 1), 32'hABCD00);
      check("pad_frame_cycles", 32'(fs_cyc_p[1] - fs_cyc_p[0]), 96);
      check("pad_bclk_period", 32'(rise_cyc_p[1] - rise_cyc_p[0]), 2);
      check("pad_lrclk_high", 32'(lr_ones(base, 48, 1)), 24);
    end
    enable_p = 1'b0;

    check("stray_underrun", 32'(stray_ur), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
